// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one bus read at a time and
// holds the returned word for the decoder; execute redirects squash in-flight work.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int                   INST_WIDTH = 32,
  parameter int                   PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ir_addr_valid,
  input  logic                  ir_addr_ready,
  output logic [PC_WIDTH-1:0]   ir_addr,
  input  logic                  ir_data_valid,
  output logic                  ir_data_ready,
  input  logic [INST_WIDTH-1:0] ir_data,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = {{(PC_WIDTH-3){1'b0}}, 3'b100};

  state_t                state_r, state_s;
  logic [PC_WIDTH-1:0]   pc_r, pc_s;
  logic [PC_WIDTH-1:0]   addr_r, addr_s;
  logic [PC_WIDTH-1:0]   inst_pc_r, inst_pc_s;
  logic [INST_WIDTH-1:0] inst_r, inst_s;
  logic                  squash_r, squash_s;
  logic                  addr_valid_r, addr_valid_s;
  logic                  data_ready_r, data_ready_s;
  logic                  inst_valid_r, inst_valid_s;
  logic [PC_WIDTH-1:0]   redirect_aligned_s;
  logic [PC_WIDTH-1:0]   pc_tgt_s;

  assign redirect_aligned_s = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  // Redirect always wins over the current pc as the next fetch target.
  assign pc_tgt_s = redirect ? redirect_aligned_s : pc_r;

  // Next-state, next-pc and next-output computation.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    addr_s    = addr_r;
    inst_s    = inst_r;
    inst_pc_s = inst_pc_r;
    squash_s  = squash_r;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_REQ;
        addr_s  = pc_r;
      end
      ST_REQ: begin
        // ir_addr keeps the old address until the pending request completes.
        pc_s     = pc_tgt_s;
        squash_s = squash_r | redirect;
        if (ir_addr_ready) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        pc_s = pc_tgt_s;
        if (ir_data_valid) begin
          if (squash_r || redirect) begin
            squash_s = 1'b0;
            addr_s   = pc_tgt_s;
            state_s  = ST_REQ;
          end else begin
            inst_s    = ir_data;
            inst_pc_s = pc_r;
            state_s   = ST_HOLD;
          end
        end else begin
          squash_s = squash_r | redirect;
          state_s  = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_s    = redirect_aligned_s;
          addr_s  = redirect_aligned_s;
          state_s = ST_REQ;
        end else if (inst_ready) begin
          pc_s    = pc_r + PC_STEP;
          addr_s  = pc_r + PC_STEP;
          state_s = ST_REQ;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        squash_s = 1'b0;
      end
    endcase
    addr_valid_s = (state_s == ST_REQ);
    data_ready_s = (state_s == ST_WAIT);
    inst_valid_s = (state_s == ST_HOLD);
  end

  // State, pc and registered output update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      addr_r       <= RESET_PC;
      inst_r       <= '0;
      inst_pc_r    <= '0;
      squash_r     <= 1'b0;
      addr_valid_r <= 1'b0;
      data_ready_r <= 1'b0;
      inst_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      addr_r       <= addr_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      squash_r     <= squash_s;
      addr_valid_r <= addr_valid_s;
      data_ready_r <= data_ready_s;
      inst_valid_r <= inst_valid_s;
    end
  end

  assign ir_addr_valid = addr_valid_r;
  assign ir_addr       = addr_r;
  assign ir_data_ready = data_ready_r;
  assign inst          = inst_r;
  assign inst_pc       = inst_pc_r;
  assign inst_valid    = inst_valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected addresses
// and instructions; a monitor pops and compares on every DUT handshake.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ir_addr_valid, ir_addr_ready = 1'b0;
  logic [31:0] ir_addr;
  logic        ir_data_valid = 1'b0, ir_data_ready;
  logic [31:0] ir_data = 32'h0;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  fetch_unit #(.INST_WIDTH(32), .PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
    .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] w; logic [31:0] pc; } exp_t;
  logic [31:0] exp_addr[$];
  exp_t        exp_inst[$];
  int          hs_cyc[$];
  int n_cmp = 0, n_err = 0, cyc = 0, flushed = 0;
  int addr_budget = 0, cons_budget = 0, addr_stall = 0, cons_stall = 0, data_delay = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a < 32'hC) return 32'h00000013;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_inst(input logic [31:0] pc);
    exp_t e;
    e.w = word_of(pc);
    e.pc = pc;
    exp_inst.push_back(e);
  endtask

  // Bus model: accepts addresses while budget allows, returns data after data_delay
  initial begin
    bit a_hs = 0, d_hs = 0, pending = 0;
    logic [31:0] a_hs_addr = 32'h0, paddr = 32'h0;
    int dly = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ir_addr_ready = 1'b0; ir_data_valid = 1'b0;
        a_hs = 0; d_hs = 0; pending = 0;
      end else begin
        if (d_hs) pending = 0;
        if (a_hs) begin pending = 1; paddr = a_hs_addr; dly = data_delay; end
        ir_addr_ready = 1'b0;
        if (ir_addr_valid && addr_budget > 0 && !pending) begin
          if (addr_stall > 0) addr_stall--;
          else ir_addr_ready = 1'b1;
        end
        a_hs = ir_addr_ready; a_hs_addr = ir_addr;
        ir_data_valid = 1'b0;
        if (pending && ir_data_ready) begin
          if (dly > 0) dly--;
          else begin ir_data_valid = 1'b1; ir_data = word_of(paddr); end
        end
        d_hs = ir_data_valid;
      end
    end
  end

  // Decoder model: consumes held instructions while budget allows
  initial begin
    forever begin
      @(negedge clk);
      inst_ready = 1'b0;
      if (rst && inst_valid && cons_budget > 0) begin
        if (cons_stall > 0) cons_stall--;
        else inst_ready = 1'b1;
      end
    end
  end

  // Monitor: compares handshakes against the scoreboard and checks hold stability
  initial begin
    bit p_av = 0, p_iv = 0;
    logic [31:0] p_addr = 32'h0, p_inst = 32'h0, p_pc = 32'h0;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst) begin
        p_av = 0; p_iv = 0;
      end else begin
        if (p_av && ir_addr_ready) begin
          if (exp_addr.size() == 0) chk("addr_unexpected", p_addr, 32'hxxxxxxxx);
          else chk("ir_addr", p_addr, exp_addr.pop_front());
          if (addr_budget > 0) addr_budget--;
        end else if (p_av) begin
          chk("addr_valid_hold", {31'h0, ir_addr_valid}, 32'h1);
          chk("addr_hold", ir_addr, p_addr);
        end
        if (p_iv && redirect) begin
          chk("flush_valid_drop", {31'h0, inst_valid}, 32'h0);
          flushed++;
          if (inst_ready && cons_budget > 0) cons_budget--;
        end else if (p_iv && inst_ready) begin
          if (exp_inst.size() == 0) begin
            chk("inst_unexpected_pc", p_pc, 32'hxxxxxxxx);
          end else begin
            e = exp_inst.pop_front();
            chk("inst", p_inst, e.w);
            chk("inst_pc", p_pc, e.pc);
          end
          hs_cyc.push_back(cyc);
          if (cons_budget > 0) cons_budget--;
        end else if (p_iv) begin
          chk("inst_valid_hold", {31'h0, inst_valid}, 32'h1);
          chk("inst_hold", inst, p_inst);
          chk("inst_pc_hold", inst_pc, p_pc);
        end
        p_av = ir_addr_valid; p_addr = ir_addr;
        p_iv = inst_valid; p_inst = inst; p_pc = inst_pc;
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300; i++) begin
      if (addr_budget == 0 && cons_budget == 0) return;
      step();
    end
    chk({name, "_timeout"}, addr_budget + cons_budget, 32'h0);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect = 1'b1; redirect_pc = pc;
    step();
    redirect = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ir_addr_valid"}, {31'h0, ir_addr_valid}, 32'h0);
    chk({tag, "_ir_data_ready"}, {31'h0, ir_data_ready}, 32'h0);
    chk({tag, "_inst_valid"},    {31'h0, inst_valid},    32'h0);
    chk({tag, "_inst"},          inst,                   32'h0);
    chk({tag, "_inst_pc"},       inst_pc,                32'h0);
    chk({tag, "_ir_addr"},       ir_addr,                32'h0);
  endtask

  initial begin
    int i;
    repeat (3) step();
    check_reset_vals("rst");

    // Zero-wait fetch of 0x0, 0x4, 0x8
    for (int k = 0; k < 3; k++) begin
      exp_addr.push_back(32'(k * 4));
      push_inst(32'(k * 4));
    end
    addr_budget = 3; cons_budget = 3;
    rst = 1'b1;
    wait_done("zero_wait");
    chk("zero_wait_count", hs_cyc.size(), 32'd3);
    if (hs_cyc.size() >= 3) begin
      chk("gap_0_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      chk("gap_1_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
    end

    // Stalled bus and decoder on 0xC
    exp_addr.push_back(32'hC); push_inst(32'hC);
    addr_stall = 4; data_delay = 3; cons_stall = 5;
    addr_budget = 1; cons_budget = 1;
    wait_done("stall");
    data_delay = 0;

    // Redirect to 0x103 while waiting for data of 0x10
    exp_addr.push_back(32'h10); exp_addr.push_back(32'h100); push_inst(32'h100);
    data_delay = 5; addr_budget = 2; cons_budget = 1;
    i = 0;
    while (!ir_data_ready && i < 50) begin step(); i++; end
    chk("wait_reached", {31'h0, ir_data_ready}, 32'h1);
    data_delay = 0;
    pulse_redirect(32'h103);
    wait_done("redir_wait");

    // Redirect coincident with address handshake of 0x104
    exp_addr.push_back(32'h104); exp_addr.push_back(32'h200); push_inst(32'h200);
    addr_budget = 2; cons_budget = 1;
    i = 0;
    do begin step(); i++; end while (!(ir_addr_valid && ir_addr_ready) && i < 50);
    pulse_redirect(32'h200);
    wait_done("redir_req");

    // Redirect coincident with decoder accept of 0x204
    exp_addr.push_back(32'h204); exp_addr.push_back(32'h300); push_inst(32'h300);
    addr_budget = 2; cons_budget = 2;
    i = 0;
    do begin step(); i++; end while (!(inst_valid && inst_ready) && i < 50);
    pulse_redirect(32'h300);
    wait_done("redir_hold");
    chk("flush_count", flushed, 32'd1);

    // Asynchronous reset while waiting for data of 0x304
    exp_addr.push_back(32'h304);
    data_delay = 10; addr_budget = 1;
    i = 0;
    while (!ir_data_ready && i < 50) begin step(); i++; end
    chk("wait_before_reset", {31'h0, ir_data_ready}, 32'h1);
    #2 rst = 1'b0;
    #1 check_reset_vals("async_rst");
    step();
    data_delay = 0;
    exp_addr.push_back(32'h0); push_inst(32'h0);
    addr_budget = 1; cons_budget = 1;
    rst = 1'b1;
    wait_done("restart");

    // Redirect to 0xFFFFFFFE while REQ of 0x4 is stalled, then wrap to 0x0
    pulse_redirect(32'hFFFFFFFE);
    exp_addr.push_back(32'h4); exp_addr.push_back(32'hFFFFFFFC); exp_addr.push_back(32'h0);
    push_inst(32'hFFFFFFFC); push_inst(32'h0);
    addr_budget = 3; cons_budget = 2;
    wait_done("wrap");

    repeat (2) step();
    chk("addr_queue_empty", exp_addr.size(), 32'd0);
    chk("inst_queue_empty", exp_inst.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction decoder. Keeps the program counter, requests one 32-bit instruction at a time over the instruction read bus (address and data channels with valid/ready), and holds the returned word on a valid/ready output consumed by the decode stage. Supports PC redirect from execute (branch/jump taken) with squash of any in-flight fetch.

## Interface

- `INST_WIDTH`, 32, instruction word width; must equal the decoder's instruction width.
- `PC_WIDTH`, 32, program counter and bus address width.
- `RESET_PC`, 0, first fetch address after reset; low 2 bits must be 0.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ir_addr_valid`  out  1  instruction address request valid.
- `ir_addr_ready`  in  1  bus accepts the address.
- `ir_addr`  out  PC_WIDTH  fetch address.
- `ir_data_valid`  in  1  bus returns instruction data.
- `ir_data_ready`  out  1  fetch unit accepts data.
- `ir_data`  in  INST_WIDTH  returned instruction word.
- `inst`  out  INST_WIDTH  instruction to decoder.
- `inst_pc`  out  PC_WIDTH  address `inst` was fetched from.
- `inst_valid`  out  1  `inst`/`inst_pc` valid.
- `inst_ready`  in  1  decode stage consumes `inst`.
- `redirect`  in  1  one-cycle pulse: restart fetch at `redirect_pc`.
- `redirect_pc`  in  PC_WIDTH  new PC; bits [1:0] ignored (treated as 0).

## Operation

- One outstanding request maximum. States: IDLE, REQ, WAIT, HOLD.
- IDLE: entered only from reset; unconditionally -> REQ on the first edge with `rst` high.
- REQ: `ir_addr_valid`=1, `ir_addr`=pc. Address and valid stay stable until `ir_addr_ready`. On handshake -> WAIT.
- WAIT: `ir_data_ready`=1. On `ir_data_valid`: if squash clear, register `ir_data` into `inst`, pc into `inst_pc`, -> HOLD; if squash set, drop data, clear squash, -> REQ.
- HOLD: `inst_valid`=1, `inst`/`inst_pc` stable. On `inst_ready`: pc <= pc+4, -> REQ.
- PC arithmetic: pc+4 modulo 2^PC_WIDTH (wraps from all-ones-aligned to 0, no flag).
- Redirect (highest priority, any state but IDLE): pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}.
  - REQ, no address handshake this cycle: stay REQ; `ir_addr` changes to new pc only after the current request completes — set squash, keep old address until handshake, then WAIT with squash.
  - REQ with handshake same cycle: -> WAIT with squash set.
  - WAIT, no data this cycle: set squash, stay WAIT. WAIT with data same cycle: drop data, -> REQ at new pc.
  - HOLD (with or without `inst_ready`): `inst_valid` falls next cycle, pc+4 not applied, -> REQ at new pc.
- Second redirect before squash resolves: pc overwritten by latest; single squash flag suffices (one outstanding).
- Reset mid-operation: all state cleared immediately; any bus response arriving later is not the unit's concern (bus is reset by the same `rst`).

## Timing

- Reset values: `ir_addr_valid`=0, `ir_data_ready`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `ir_addr`=RESET_PC, pc=RESET_PC, squash=0, state=IDLE.
- All outputs driven from registers/state only; no combinational path from any input to any output.
- Address handshake at edge N -> `ir_data_ready` high from N; data accepted at edge M>=N+1 -> `inst_valid` high from M.
- `inst_ready` at edge K -> `ir_addr_valid` with pc+4 from K. Zero-wait bus: one instruction per 3 cycles.
- Redirect at edge R in HOLD -> `ir_addr_valid` with redirect address from R+0 (visible after edge R).

## Test plan

- Reset then zero-wait bus returning 0x00000013 at 0x0,0x4,0x8 -> `ir_addr` sequence 0x0,0x4,0x8; `inst_pc` matches; `inst_valid` every 3rd cycle; reset values checked during `rst`=0.
- Bus stalls: `ir_addr_ready` low 4 cycles, `ir_data_valid` late 3 cycles, `inst_ready` low 5 cycles -> address/valid/inst stable throughout, no duplicate or skipped PC.
- Redirect to 0x103 while in WAIT -> in-flight word dropped (never on `inst`), next `ir_addr`=0x100, next `inst_pc`=0x100.
- Redirect coincident with `ir_addr_ready` in REQ, and separately coincident with `inst_ready` in HOLD -> old response squashed / pc+4 not applied; next fetch at redirect address.
- PC wrap: RESET_PC=0xFFFFFFFC -> second fetch address 0x00000000.
- Assert `rst` low during WAIT -> all outputs at reset values asynchronously; after release, fetch restarts at RESET_PC.
